// File: rtl/riscv_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_cache_pkg
// Description : Cache geometry helper functions shared by the cache blocks.
//               Cache size is expressed in kilobytes, block size in bits.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_cache_pkg;

  // Number of sets for a cache of cache_size KB, block_size bits, ways ways
  function automatic integer no_of_sets(input integer cache_size,
                                        input integer block_size,
                                        input integer ways);
    return (cache_size * 1024 * 8) / block_size / ways;
  endfunction

  // Byte-offset bits inside one block
  function automatic integer no_of_block_offset_bits(input integer block_size);
    return $clog2(block_size / 8);
  endfunction

  // Set-index bits
  function automatic integer no_of_index_bits(input integer sets);
    return (sets > 1) ? $clog2(sets) : 1;
  endfunction

  // Tag bits left over from the address
  function automatic integer no_of_tag_bits(input integer xlen,
                                            input integer idx_bits,
                                            input integer blk_offs_bits);
    return xlen - idx_bits - blk_offs_bits;
  endfunction

  // Pointer width for a write buffer of the given depth
  function automatic integer no_of_wbuf_ptr_bits(input integer depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_cache_wbuf.sv
`default_nettype none
// ============================================================================
// Module      : riscv_cache_wbuf
// Description : Cache write buffer. Holds store data after tag compare in a
//               small FIFO and drains it into the data memory whenever the
//               address setup stage is not reading. Flags reads that target
//               a block still waiting in the buffer.
//               Optional feature macro: RV_CACHE_WBUF_MERGE_EN (merge a push
//               into the tail-most entry when block address and way match).
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_cache_wbuf
  import riscv_cache_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SIZE       = 64,
  parameter int BLOCK_SIZE = XLEN,
  parameter int WAYS       = 2,
  parameter int DEPTH      = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,

  input  logic                    wr_req_i,
  input  logic [XLEN-1:0]         wr_adr_i,
  input  logic [WAYS-1:0]         wr_way_i,
  input  logic [XLEN/8-1:0]       wr_be_i,
  input  logic [XLEN-1:0]         wr_d_i,
  output logic                    full_o,
  output logic                    empty_o,

  input  logic                    rd_req_i,
  input  logic [XLEN-1:0]         rd_adr_i,
  output logic                    conflict_o,

  output logic                    mem_we_o,
  output logic [no_of_index_bits(no_of_sets(SIZE, BLOCK_SIZE, WAYS))-1:0] mem_idx_o,
  output logic [WAYS-1:0]         mem_way_o,
  output logic [BLOCK_SIZE/8-1:0] mem_be_o,
  output logic [BLOCK_SIZE-1:0]   mem_d_o
);

  localparam int SETS          = no_of_sets(SIZE, BLOCK_SIZE, WAYS);
  localparam int BLK_OFFS_BITS = no_of_block_offset_bits(BLOCK_SIZE);
  localparam int IDX_BITS      = no_of_index_bits(SETS);
  localparam int TAG_BITS      = no_of_tag_bits(XLEN, IDX_BITS, BLK_OFFS_BITS);
  localparam int PTR_BITS      = no_of_wbuf_ptr_bits(DEPTH);
  localparam int CNT_BITS      = PTR_BITS + 1;
  localparam int BLK_ADR_BITS  = XLEN - BLK_OFFS_BITS;
  localparam int BLK_BYTES     = BLOCK_SIZE / 8;
  localparam int WORD_BITS     = $clog2(XLEN / 8);
  localparam int WORDS         = BLOCK_SIZE / XLEN;
  localparam int WSEL_BITS     = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef struct packed {
    logic                    valid;
    logic [BLK_ADR_BITS-1:0] adr;
    logic [WAYS-1:0]         way;
    logic [BLK_BYTES-1:0]    be;
    logic [BLOCK_SIZE-1:0]   d;
  } entry_t;

  entry_t                entry_q [DEPTH];
  entry_t                entry_d [DEPTH];
  logic [PTR_BITS-1:0]   wptr_q, wptr_d;
  logic [PTR_BITS-1:0]   rptr_q, rptr_d;
  logic [CNT_BITS-1:0]   cnt_q,  cnt_d;

  logic [BLK_ADR_BITS-1:0] wr_blk;
  logic [BLK_ADR_BITS-1:0] rd_blk;
  logic [WSEL_BITS-1:0]    wr_word;
  logic [BLOCK_SIZE-1:0]   wr_d_blk;
  logic [BLK_BYTES-1:0]    wr_be_blk;
  logic [BLOCK_SIZE-1:0]   wr_mask;
  logic [PTR_BITS-1:0]     tail_ptr;
  logic                    rd_hit;
  logic                    pop;
  logic                    merge;
  logic                    alloc;
  logic                    unused_bits;

  assign wr_blk   = wr_adr_i[XLEN-1:BLK_OFFS_BITS];
  assign rd_blk   = rd_adr_i[XLEN-1:BLK_OFFS_BITS];
  assign tail_ptr = wptr_q - PTR_BITS'(1);

  // Word position of the store inside the block; single-word blocks use 0
  generate
    if (WORDS > 1) begin : g_multi_word
      assign wr_word = wr_adr_i[BLK_OFFS_BITS-1:WORD_BITS];
    end else begin : g_single_word
      assign wr_word = '0;
    end
  endgenerate

  assign wr_d_blk  = BLOCK_SIZE'(wr_d_i) << (XLEN * wr_word);
  assign wr_be_blk = BLK_BYTES'(wr_be_i) << ((XLEN / 8) * wr_word);

  // Expand block byte enables to a bit mask for byte-wise overwrite on merge
  always_comb begin
    wr_mask = '0;
    for (int b = 0; b < BLK_BYTES; b++) begin
      wr_mask[b*8 +: 8] = {8{wr_be_blk[b]}};
    end
  end

  // Read-after-write check against every valid entry
  always_comb begin
    rd_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_q[i].valid && (entry_q[i].adr == rd_blk)) begin
        rd_hit = 1'b1;
      end
    end
  end

  assign empty_o    = (cnt_q == '0);
  assign full_o     = (cnt_q == CNT_BITS'(DEPTH));
  assign conflict_o = rd_req_i & rd_hit;
  assign mem_we_o   = ~empty_o & (~rd_req_i | conflict_o);
  assign pop        = mem_we_o;

`ifdef RV_CACHE_WBUF_MERGE_EN
  // Merge into the newest entry unless it is the head leaving this cycle
  assign merge = wr_req_i & ~empty_o
               & (entry_q[tail_ptr].adr == wr_blk)
               & (entry_q[tail_ptr].way == wr_way_i)
               & ~(pop & (cnt_q == CNT_BITS'(1)));
`else
  assign merge = 1'b0;
`endif

  assign alloc = wr_req_i & ~merge & ~full_o;

  assign mem_idx_o = entry_q[rptr_q].adr[IDX_BITS-1:0];
  assign mem_way_o = entry_q[rptr_q].way;
  assign mem_be_o  = entry_q[rptr_q].be;
  assign mem_d_o   = entry_q[rptr_q].d;

  // Next-state: pop the head, then merge or allocate at the tail
  always_comb begin
    entry_d = entry_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;

    if (pop) begin
      entry_d[rptr_q] = '0;
      rptr_d          = rptr_q + PTR_BITS'(1);
    end

    if (merge) begin
      entry_d[tail_ptr].be = entry_q[tail_ptr].be | wr_be_blk;
      entry_d[tail_ptr].d  = (entry_q[tail_ptr].d & ~wr_mask) | (wr_d_blk & wr_mask);
    end else if (alloc) begin
      entry_d[wptr_q].valid = 1'b1;
      entry_d[wptr_q].adr   = wr_blk;
      entry_d[wptr_q].way   = wr_way_i;
      entry_d[wptr_q].be    = wr_be_blk;
      entry_d[wptr_q].d     = wr_d_blk;
      wptr_d                = wptr_q + PTR_BITS'(1);
    end

    cnt_d = cnt_q + CNT_BITS'(alloc) - CNT_BITS'(pop);
  end

  // Buffer state registers; reset discards all entries at once
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      entry_q <= entry_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Address bits below block granularity and the tag width are not needed here
  assign unused_bits = ^{wr_adr_i[WORD_BITS-1:0], rd_adr_i[BLK_OFFS_BITS-1:0],
                         1'(TAG_BITS)};

endmodule
`default_nettype wire

// File: tb/tb_riscv_cache_wbuf.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_cache_wbuf
// Description : Self-checking bench for riscv_cache_wbuf (XLEN=32,
//               BLOCK_SIZE=128, DEPTH=2): directed vector table, a reset
//               during drain, and randomized traffic against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_cache_wbuf;

  localparam int XLEN       = 32;
  localparam int SIZE       = 64;
  localparam int BLOCK_SIZE = 128;
  localparam int WAYS       = 2;
  localparam int DEPTH      = 2;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         wr_req_i = 1'b0;
  logic [31:0]  wr_adr_i = '0;
  logic [1:0]   wr_way_i = '0;
  logic [3:0]   wr_be_i  = '0;
  logic [31:0]  wr_d_i   = '0;
  logic         full_o, empty_o;
  logic         rd_req_i = 1'b0;
  logic [31:0]  rd_adr_i = '0;
  logic         conflict_o;
  logic         mem_we_o;
  logic [11:0]  mem_idx_o;
  logic [1:0]   mem_way_o;
  logic [15:0]  mem_be_o;
  logic [127:0] mem_d_o;

  int n_checks = 0;
  int n_errors = 0;

  riscv_cache_wbuf #(
    .XLEN(XLEN), .SIZE(SIZE), .BLOCK_SIZE(BLOCK_SIZE), .WAYS(WAYS), .DEPTH(DEPTH)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wr_req_i(wr_req_i), .wr_adr_i(wr_adr_i), .wr_way_i(wr_way_i),
    .wr_be_i(wr_be_i), .wr_d_i(wr_d_i), .full_o(full_o), .empty_o(empty_o),
    .rd_req_i(rd_req_i), .rd_adr_i(rd_adr_i), .conflict_o(conflict_o),
    .mem_we_o(mem_we_o), .mem_idx_o(mem_idx_o), .mem_way_o(mem_way_o),
    .mem_be_o(mem_be_o), .mem_d_o(mem_d_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic drive(input logic wr, input logic [31:0] wa, input logic [1:0] ww,
                       input logic [3:0] wb, input logic [31:0] wd,
                       input logic rr, input logic [31:0] ra);
    wr_req_i = wr; wr_adr_i = wa; wr_way_i = ww; wr_be_i = wb; wr_d_i = wd;
    rd_req_i = rr; rd_adr_i = ra;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic         wr;
    logic [31:0]  wa;
    logic [1:0]   ww;
    logic [3:0]   wb;
    logic [31:0]  wd;
    logic         rr;
    logic [31:0]  ra;
    logic         e_empty, e_full, e_conf, e_we;
    logic [11:0]  e_idx;
    logic [1:0]   e_way;
    logic [15:0]  e_be;
    logic [127:0] e_d;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic wr, input logic [31:0] wa, input logic [1:0] ww,
                              input logic [3:0] wb, input logic [31:0] wd,
                              input logic rr, input logic [31:0] ra,
                              input logic ee, input logic ef, input logic ec, input logic ew,
                              input logic [11:0] ei, input logic [1:0] eway,
                              input logic [15:0] ebe, input logic [127:0] ed);
    vec_t v;
    v.wr = wr; v.wa = wa; v.ww = ww; v.wb = wb; v.wd = wd; v.rr = rr; v.ra = ra;
    v.e_empty = ee; v.e_full = ef; v.e_conf = ec; v.e_we = ew;
    v.e_idx = ei; v.e_way = eway; v.e_be = ebe; v.e_d = ed;
    vecs.push_back(v);
  endfunction

  function automatic void build_table();
    // single push, drains next cycle at word 1
    add(1, 32'h104, 2'b01, 4'hF, 32'hDEADBEEF, 0, 0,  1,0,0,0, 0,0,0,0);
    add(0, 0, 0, 0, 0, 0, 0,  0,0,0,1, 12'h010, 2'b01, 16'h00F0, 128'hDEADBEEF_00000000);
    add(0, 0, 0, 0, 0, 0, 0,  1,0,0,0, 0,0,0,0);
    // fill while reads hold off draining; third write dropped
    add(1, 32'h1000, 2'b01, 4'h3, 32'h11112222, 1, 32'h8000,  1,0,0,0, 0,0,0,0);
    add(1, 32'h2004, 2'b10, 4'hF, 32'h33334444, 1, 32'h8000,  0,0,0,0, 0,0,0,0);
    add(1, 32'h3008, 2'b01, 4'hF, 32'h55556666, 1, 32'h8000,  0,1,0,0, 0,0,0,0);
    add(0, 0, 0, 0, 0, 0, 0,  0,1,0,1, 12'h100, 2'b01, 16'h0003, 128'h11112222);
    add(0, 0, 0, 0, 0, 0, 0,  0,0,0,1, 12'h200, 2'b10, 16'h00F0, 128'h33334444_00000000);
    add(0, 0, 0, 0, 0, 0, 0,  1,0,0,0, 0,0,0,0);
    // conflict forces a drain under a read
    add(1, 32'h200, 2'b01, 4'hF, 32'hCAFEF00D, 0, 0,  1,0,0,0, 0,0,0,0);
    add(0, 0, 0, 0, 0, 1, 32'h20C,  0,0,1,1, 12'h020, 2'b01, 16'h000F, 128'hCAFEF00D);
    add(0, 0, 0, 0, 0, 1, 32'h20C,  1,0,0,0, 0,0,0,0);
    // one pending entry, then 5 push+pop pairs wrapping the pointers
    add(1, 32'h400, 2'b01, 4'hF, 32'hA0, 0, 0,  1,0,0,0, 0,0,0,0);
    for (int k = 1; k <= 5; k++) begin
      add(1, 32'h400 + 32'(16*k), 2'b01, 4'hF, 32'hA0 + 32'(k), 0, 0,
          0,0,0,1, 12'h040 + 12'(k-1), 2'b01, 16'h000F, 128'(32'hA0 + 32'(k-1)));
    end
    add(0, 0, 0, 0, 0, 0, 0,  0,0,0,1, 12'h045, 2'b01, 16'h000F, 128'hA5);
    add(0, 0, 0, 0, 0, 0, 0,  1,0,0,0, 0,0,0,0);
    // two writes to the same block and way while reads hold off draining
    add(1, 32'h300, 2'b01, 4'h1, 32'h00000011, 1, 32'h8000,  1,0,0,0, 0,0,0,0);
    add(1, 32'h302, 2'b01, 4'h4, 32'h00220000, 1, 32'h8000,  0,0,0,0, 0,0,0,0);
`ifdef RV_CACHE_WBUF_MERGE_EN
    add(0, 0, 0, 0, 0, 1, 32'h8000,  0,0,0,0, 0,0,0,0);
    add(0, 0, 0, 0, 0, 0, 0,  0,0,0,1, 12'h030, 2'b01, 16'h0005, 128'h00220011);
    add(0, 0, 0, 0, 0, 0, 0,  1,0,0,0, 0,0,0,0);
`else
    add(0, 0, 0, 0, 0, 1, 32'h8000,  0,1,0,0, 0,0,0,0);
    add(0, 0, 0, 0, 0, 0, 0,  0,1,0,1, 12'h030, 2'b01, 16'h0001, 128'h00000011);
    add(0, 0, 0, 0, 0, 0, 0,  0,0,0,1, 12'h030, 2'b01, 16'h0004, 128'h00220000);
`endif
    add(0, 0, 0, 0, 0, 0, 0,  1,0,0,0, 0,0,0,0);
  endfunction

  // ---------------- behavioural reference model ----------------
  typedef struct {
    logic [27:0]  blk;
    logic [1:0]   way;
    logic [15:0]  be;
    logic [127:0] d;
  } ent_t;

  ent_t mq[$];

  // Check one cycle's outputs against the model, then advance the model
  task automatic model_cycle(input logic wr, input logic [31:0] wa, input logic [1:0] ww,
                             input logic [3:0] wb, input logic [31:0] wd,
                             input logic rr, input logic [31:0] ra);
    int   n0;
    logic e_empty, e_full, e_conf, e_we, merged;
    int   word;
    ent_t ne;
    n0      = mq.size();
    e_empty = (n0 == 0);
    e_full  = (n0 == DEPTH);
    e_conf  = 1'b0;
    foreach (mq[i]) if (rr && mq[i].blk == ra[31:4]) e_conf = 1'b1;
    e_we = !e_empty && (!rr || e_conf);
    chk("rnd_empty", 128'(empty_o), 128'(e_empty));
    chk("rnd_full", 128'(full_o), 128'(e_full));
    chk("rnd_conflict", 128'(conflict_o), 128'(e_conf));
    chk("rnd_we", 128'(mem_we_o), 128'(e_we));
    if (e_we) begin
      chk("rnd_idx", 128'(mem_idx_o), 128'(mq[0].blk[11:0]));
      chk("rnd_way", 128'(mem_way_o), 128'(mq[0].way));
      chk("rnd_be", 128'(mem_be_o), 128'(mq[0].be));
      chk("rnd_d", mem_d_o, mq[0].d);
    end
    word   = int'(wa[3:2]);
    ne.blk = wa[31:4];
    ne.way = ww;
    ne.be  = 16'(wb) << (4 * word);
    ne.d   = 128'(wd) << (32 * word);
    merged = 1'b0;
`ifdef RV_CACHE_WBUF_MERGE_EN
    if (wr && n0 > 0 && mq[n0-1].blk == ne.blk && mq[n0-1].way == ww && !(e_we && n0 == 1)) begin
      for (int b = 0; b < 16; b++) begin
        if (ne.be[b]) mq[n0-1].d[b*8 +: 8] = ne.d[b*8 +: 8];
      end
      mq[n0-1].be = mq[n0-1].be | ne.be;
      merged = 1'b1;
    end
`endif
    if (e_we) void'(mq.pop_front());
    if (wr && !merged && n0 < DEPTH) mq.push_back(ne);
  endtask

  initial begin
    build_table();

    // reset state
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset_empty", 128'(empty_o), 128'(1));
    chk("reset_full", 128'(full_o), 128'(0));
    chk("reset_conflict", 128'(conflict_o), 128'(0));
    chk("reset_we", 128'(mem_we_o), 128'(0));
    chk("reset_idx", 128'(mem_idx_o), 128'(0));
    chk("reset_way", 128'(mem_way_o), 128'(0));
    chk("reset_be", 128'(mem_be_o), 128'(0));
    chk("reset_d", mem_d_o, 128'(0));
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // directed vector table
    foreach (vecs[i]) begin
      drive(vecs[i].wr, vecs[i].wa, vecs[i].ww, vecs[i].wb, vecs[i].wd, vecs[i].rr, vecs[i].ra);
      @(negedge clk_i);
      chk($sformatf("vec%0d_empty", i), 128'(empty_o), 128'(vecs[i].e_empty));
      chk($sformatf("vec%0d_full", i), 128'(full_o), 128'(vecs[i].e_full));
      chk($sformatf("vec%0d_conflict", i), 128'(conflict_o), 128'(vecs[i].e_conf));
      chk($sformatf("vec%0d_we", i), 128'(mem_we_o), 128'(vecs[i].e_we));
      if (vecs[i].e_we) begin
        chk($sformatf("vec%0d_idx", i), 128'(mem_idx_o), 128'(vecs[i].e_idx));
        chk($sformatf("vec%0d_way", i), 128'(mem_way_o), 128'(vecs[i].e_way));
        chk($sformatf("vec%0d_be", i), 128'(mem_be_o), 128'(vecs[i].e_be));
        chk($sformatf("vec%0d_d", i), mem_d_o, vecs[i].e_d);
      end
      @(posedge clk_i); #1;
    end

    // reset asserted while an entry is draining
    drive(1, 32'h500, 2'b01, 4'hF, 32'h12345678, 1, 32'h8000);
    @(posedge clk_i); #1;
    drive(1, 32'h510, 2'b10, 4'hF, 32'h9ABCDEF0, 1, 32'h8000);
    @(posedge clk_i); #1;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    chk("middrain_we_before", 128'(mem_we_o), 128'(1));
    #1 rst_i = 1'b1;
    #1;
    chk("middrain_we_async", 128'(mem_we_o), 128'(0));
    chk("middrain_empty_async", 128'(empty_o), 128'(1));
    chk("middrain_be_async", 128'(mem_be_o), 128'(0));
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("middrain_empty_after", 128'(empty_o), 128'(1));
    chk("middrain_we_after", 128'(mem_we_o), 128'(0));
    @(posedge clk_i); #1;
    mq.delete();

    // randomized traffic against the model
    for (int c = 0; c < 2000; c++) begin
      logic        wr, rr;
      logic [31:0] wa, ra, wd;
      logic [1:0]  ww;
      logic [3:0]  wb;
      wr = 1'($urandom_range(0, 1));
      rr = ($urandom_range(0, 2) == 0);
      wa = (32'($urandom_range(0, 5)) << 4) | (32'($urandom_range(0, 3)) << 2);
      ra = (32'($urandom_range(0, 7)) << 4) | 32'($urandom_range(0, 15));
      ww = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b01;
      wb = 4'($urandom_range(1, 15));
      wd = $urandom;
      drive(wr, wa, ww, wb, wd, rr, ra);
      @(negedge clk_i);
      model_cycle(wr, wa, ww, wb, wd, rr, ra);
      @(posedge clk_i); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/riscv_cache_wbuf.md
# riscv_cache_wbuf

Cache write buffer: the writer side of the cache memories whose read port is driven by the address setup stage. It accepts store data from the cache pipeline after tag compare and holds it in a small FIFO. Each entry drains into the tag-indexed data memory in a cycle when the setup stage is not issuing a read. It flags read-after-write conflicts so a pending write is never bypassed by a read of the same block.

## Interface
Parameters:
- XLEN, 32, core data/address width
- SIZE, 64, cache size (same unit as riscv_cache_pkg functions)
- BLOCK_SIZE, XLEN, cache block width in bits
- WAYS, 2, associativity
- DEPTH, 2, buffer entries (power of 2, ≥2)
- Derived localparams: SETS, BLK_OFFS_BITS, IDX_BITS and TAG_BITS, computed with the riscv_cache_pkg functions.

Ports:
- clk_i  in  1  clock; all state updates on its rising edge
- rst_i  in  1  asynchronous, active-high reset
- wr_req_i  in  1  store to buffer
- wr_adr_i  in  XLEN  physical store address
- wr_way_i  in  WAYS  one-hot way that hit
- wr_be_i  in  XLEN/8  byte enables
- wr_d_i  in  XLEN  store data
- full_o  out  1  no free entry; wr_req_i is ignored while high
- empty_o  out  1  no valid entry
- rd_req_i  in  1  setup-stage read this cycle (req_rd_o of setup)
- rd_adr_i  in  XLEN  setup-stage read address
- conflict_o  out  1  a valid entry holds rd_adr_i's block
- mem_we_o  out  1  data-memory write strobe
- mem_idx_o  out  IDX_BITS  set index
- mem_way_o  out  WAYS  way select
- mem_be_o  out  BLOCK_SIZE/8  block byte enables
- mem_d_o  out  BLOCK_SIZE  block write data

## Operation
- Each entry holds: valid, block address adr[XLEN-1:BLK_OFFS_BITS], way, block-wide be and data.
- Push: wr_req_i && !full_o stores the entry at the tail.
  - Data is placed at word offset w = adr[BLK_OFFS_BITS-1:log2(XLEN/8)]: data at bits w*XLEN, be at bits w*XLEN/8, all other be bits 0.
  - When BLOCK_SIZE==XLEN, w is 0.
- Conflict: conflict_o = rd_req_i && any valid entry with block address == rd_adr_i[XLEN-1:BLK_OFFS_BITS]. The setup stage stalls on it.
- Drain: mem_we_o = !empty_o && (!rd_req_i || conflict_o). The memory accepts every cycle, so the head pops in the same cycle mem_we_o is high.
- mem_* outputs are driven from the head entry. mem_idx_o is the low IDX_BITS of the block address.
- Count/pointers: push and pop in the same cycle leave the count unchanged. Pointers wrap modulo DEPTH.
- full_o = (count==DEPTH) and is not relieved by a same-cycle pop. A write presented while full is dropped; the pipeline must stall on full_o.

## Timing
- Reset state: all entries invalid, count 0, empty_o=1, full_o=0, conflict_o=0, mem_we_o=0, mem_* data outputs 0.
- No bypass path. A push at edge N can drive mem_we_o at the earliest in cycle N+1.
- full_o, empty_o and conflict_o are combinational from registered state plus rd_*; they carry no input→output path from wr_*.
- Reset asserted mid-drain discards all entries immediately; mem_we_o drops asynchronously.
- Drain throughput: 1 entry per cycle while rd_req_i is low.

## Configuration
- RV_CACHE_WBUF_MERGE_EN defined: a push whose block address and way equal the tail-most valid entry is merged into it. Merged be bits are OR-ed; new bytes overwrite old ones. The count is unchanged, and merging is allowed while full.
  - Exception: if that entry is the head and pops in the same cycle, no merge occurs; a new entry is allocated instead, and only if not full.
- Not defined: every push allocates a new entry.

## Structure
- riscv_cache_pkg: the existing no_of_sets, no_of_block_offset_bits, no_of_index_bits and no_of_tag_bits functions are reused. Add a no_of_wbuf_ptr_bits(DEPTH) function.
- The entry struct is parameter-dependent and is declared locally in the module.
- No sub-module; the FIFO storage is an entry array inside the module.

## Test plan
Benches use XLEN=32 and BLOCK_SIZE=128.
- Reset state: assert rst_i → empty_o=1, full_o=0, mem_we_o=0 and all mem_* = 0.
- Single push: push adr 0x104, be 0xF, d 0xDEADBEEF with rd_req_i=0.
  - Next cycle mem_we_o=1, mem_be_o=0x00F0, mem_d_o[63:32]=0xDEADBEEF.
  - Cycle after that, empty_o=1.
- Fill: hold rd_req_i=1 (no conflict) and push 3 writes to distinct blocks.
  - full_o=1 after the 2nd push and the 3rd write is dropped.
  - Release rd_req_i → 2 writes in 2 consecutive cycles, no third.
- Conflict: buffer 0x200, then rd_req_i=1 with rd_adr_i=0x20C → conflict_o=1 and mem_we_o=1 the same cycle. Next cycle conflict_o=0.
- Simultaneous push+pop with DEPTH=2 and one entry pending → count stays 1 and pointer wrap is verified over 5 pairs.
- Merge (macro on): with rd_req_i held high, write 0x300 be 0x1 d 0x11, then 0x302 be 0x4 d 0x00220000 → one entry. Drain gives mem_be_o=0x0005 and data bytes 0x11 and 0x22. Macro off → two drains.
